// File: rtl/t05_sram_pkg.sv
// Shared types and constants for the team_05 SRAM burst port.
//   burst_state_t : burst sequencer states
//   *_BASE        : SRAM region base byte addresses of the compute clients
//   WORD_STRIDE   : byte distance between consecutive bus words
package t05_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } burst_state_t;

  localparam logic [31:0] HIST_BASE  = 32'd0;
  localparam logic [31:0] HTREE_BASE = 32'd1024;
  localparam logic [31:0] CB_BASE    = 32'd2048;
  localparam logic [31:0] TRN_BASE   = 32'd0;

  localparam int unsigned WORD_STRIDE = 4;

  // Index width that stays at least one bit for a single client.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t05_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-client request level
//   served : clients already served that have not yet dropped req
//   ptr    : highest-priority client index
//   grant  : first eligible client at or after ptr (wrapping)
//   valid  : some client is eligible
module t05_rr_arbiter
  import t05_sram_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [NUM_CLIENTS-1:0] served,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       grant,
  output logic                   valid
);

  logic [NUM_CLIENTS-1:0] eligible;
  logic [IDX_W-1:0]       cand;

  // Scan from ptr upwards, taking the first eligible client.
  always_comb begin
    eligible = req & ~served;
    grant    = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_CLIENTS);
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/t05_sram_burst_port.sv
// Multi-client SRAM burst engine in front of the wishbone SRAM master.
//   clk, nRst  : clock, asynchronous active-low reset
//   req*       : per-client burst requests (level, held until done/err)
//   rsp_rdata  : assembled read data shared by all clients
//   rsp_done   : one-cycle completion pulse per client
//   rsp_err    : one-cycle timeout pulse per client
//   wr_en/r_en : one-cycle bus strobes; addr/data_i held until next strobe
//   select     : byte select, always all lanes
//   data_o     : bus read data; busy_o : bus busy
module t05_sram_burst_port
  import t05_sram_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_WORDS   = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                         clk,
  input  logic                                         nRst,
  input  logic [NUM_CLIENTS-1:0]                       req,
  input  logic [NUM_CLIENTS-1:0]                       req_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]                req_addr,
  input  logic [NUM_CLIENTS*$clog2(MAX_WORDS+1)-1:0]   req_len,
  input  logic [NUM_CLIENTS*MAX_WORDS*DATA_W-1:0]      req_wdata,
  output logic [MAX_WORDS*DATA_W-1:0]                  rsp_rdata,
  output logic [NUM_CLIENTS-1:0]                       rsp_done,
  output logic [NUM_CLIENTS-1:0]                       rsp_err,
  output logic                                         wr_en,
  output logic                                         r_en,
  output logic [3:0]                                   select,
  output logic [ADDR_W-1:0]                            addr,
  output logic [DATA_W-1:0]                            data_i,
  input  logic [DATA_W-1:0]                            data_o,
  input  logic                                         busy_o
);

  localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);
  localparam int unsigned BUF_W = MAX_WORDS * DATA_W;

  burst_state_t           state_q, state_n;
  logic [IDX_W-1:0]       grant_q, grant_n;
  logic [IDX_W-1:0]       ptr_q, ptr_n;
  logic                   wr_q, wr_n;
  logic [ADDR_W-1:0]      base_q, base_n;
  logic [LEN_W-1:0]       len_q, len_n;
  logic [LEN_W-1:0]       wcnt_q, wcnt_n;
  logic [BUF_W-1:0]       wbuf_q, wbuf_n;
  logic [TO_W-1:0]        to_q, to_n;
  logic                   err_q, err_n;
  logic [NUM_CLIENTS-1:0] served_q, served_n;

  logic [BUF_W-1:0]       rdata_n;
  logic [NUM_CLIENTS-1:0] done_n, errp_n;
  logic                   wr_en_n, r_en_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [DATA_W-1:0]      data_i_n;

  logic [IDX_W-1:0]       arb_grant;
  logic                   arb_valid;
  logic [LEN_W-1:0]       len_sel;

  assign select = 4'b1111;

  t05_rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req    (req),
    .served (served_q),
    .ptr    (ptr_q),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state_q;
    grant_n  = grant_q;
    ptr_n    = ptr_q;
    wr_n     = wr_q;
    base_n   = base_q;
    len_n    = len_q;
    wcnt_n   = wcnt_q;
    wbuf_n   = wbuf_q;
    to_n     = to_q;
    err_n    = err_q;
    served_n = served_q & req;   // a client becomes eligible again once it drops req
    rdata_n  = rsp_rdata;
    done_n   = '0;
    errp_n   = '0;
    wr_en_n  = 1'b0;
    r_en_n   = 1'b0;
    addr_n   = addr;
    data_i_n = data_i;
    len_sel  = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_n = arb_grant;
          err_n   = 1'b0;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_grant == IDX_W'(i)) begin
              wr_n    = req_wr[i];
              base_n  = req_addr[i*ADDR_W +: ADDR_W];
              len_sel = req_len[i*LEN_W +: LEN_W];
              wbuf_n  = req_wdata[i*BUF_W +: BUF_W];
            end
          end
          len_n = (len_sel > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : len_sel;
          if (len_n == '0) begin
            state_n = FINISH;
          end else begin
            if (!wr_n) rdata_n = '0;
            wcnt_n  = '0;
            state_n = ISSUE;
          end
        end
      end

      ISSUE: begin
        to_n    = '0;
        state_n = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (busy_o) begin
          state_n = WAIT_DONE;
        end else begin
          to_n = to_q + TO_W'(1);
          if (to_n == TO_W'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = FINISH;
          end
        end
      end

      WAIT_DONE: begin
        if (!busy_o) begin
          if (!wr_q) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
              if (wcnt_q == LEN_W'(k)) rdata_n[k*DATA_W +: DATA_W] = data_o;
            end
          end
          wcnt_n  = wcnt_q + LEN_W'(1);
          state_n = (wcnt_n == len_q) ? FINISH : ISSUE;
        end
      end

      FINISH: begin
        state_n = IDLE;
        ptr_n   = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + IDX_W'(1);
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (grant_q == IDX_W'(i)) served_n[i] = req[i];
        end
      end

      default: state_n = IDLE;
    endcase

    // Strobe, address and write word are launched on entry to ISSUE.
    if (state_n == ISSUE) begin
      wr_en_n = wr_n;
      r_en_n  = !wr_n;
      addr_n  = base_n + ADDR_W'(wcnt_n) * ADDR_W'(WORD_STRIDE);
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (wcnt_n == LEN_W'(k)) data_i_n = wbuf_n[k*DATA_W +: DATA_W];
      end
    end

    // Completion pulse is high for the single FINISH cycle.
    if (state_n == FINISH) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (grant_n == IDX_W'(i)) begin
          if (err_n) errp_n[i] = 1'b1;
          else       done_n[i] = 1'b1;
        end
      end
    end
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      wr_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      wbuf_q    <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      served_q  <= '0;
      rsp_rdata <= '0;
      rsp_done  <= '0;
      rsp_err   <= '0;
      wr_en     <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
      data_i    <= '0;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      ptr_q     <= ptr_n;
      wr_q      <= wr_n;
      base_q    <= base_n;
      len_q     <= len_n;
      wcnt_q    <= wcnt_n;
      wbuf_q    <= wbuf_n;
      to_q      <= to_n;
      err_q     <= err_n;
      served_q  <= served_n;
      rsp_rdata <= rdata_n;
      rsp_done  <= done_n;
      rsp_err   <= errp_n;
      wr_en     <= wr_en_n;
      r_en      <= r_en_n;
      addr      <= addr_n;
      data_i    <= data_i_n;
    end
  end

endmodule

// File: tb/tb_t05_sram_burst_port.sv
// Scoreboard bench for t05_sram_burst_port: expected bus words and
// completions are queued when a request is driven and popped by monitors.
module tb_t05_sram_burst_port;
  import t05_sram_pkg::*;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 32;
  localparam int TO = 255;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              nRst;
  logic [NC-1:0]     req;
  logic [NC-1:0]     req_wr;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*LW-1:0]  req_len;
  logic [NC*MW*DW-1:0] req_wdata;
  logic [MW*DW-1:0]  rsp_rdata;
  logic [NC-1:0]     rsp_done;
  logic [NC-1:0]     rsp_err;
  logic              wr_en;
  logic              r_en;
  logic [3:0]        select;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data_i;
  logic [DW-1:0]     data_o;
  logic              busy_o;

  t05_sram_burst_port dut (
    .clk       (clk),
    .nRst      (nRst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_rdata (rsp_rdata),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .r_en      (r_en),
    .select    (select),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] rd_q[$];
  logic [7:0]  exp_cpl[$];   // {err, done}
  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  bit          hang = 1'b0;

  // Bus slave: one idle cycle after a strobe, then a one-cycle busy pulse.
  logic [31:0] rsp_val;
  initial begin
    busy_o = 1'b0;
    data_o = '0;
    forever begin
      @(posedge clk);
      #1;
      if (nRst && (r_en || wr_en) && !hang) begin
        rsp_val = (r_en && rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        @(posedge clk);
        #1 busy_o = 1'b1;
        @(posedge clk);
        #1 busy_o = 1'b0;
        data_o = rsp_val;
      end
    end
  end

  // Monitor: every strobe and completion pulse is checked against the queues.
  bus_t       eb;
  logic [7:0] ec;
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en || r_en) begin
        strobe_cnt++;
        total++;
        if (exp_bus.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected addr=%h wr_en=%b r_en=%b", addr, wr_en, r_en);
        end else begin
          eb = exp_bus.pop_front();
          if (addr !== eb.a || wr_en !== eb.w || r_en !== !eb.w || (eb.w && data_i !== eb.d)) begin
            bad++;
            $display("FAIL strobe got addr=%h wr=%b rd=%b data=%h exp addr=%h wr=%b data=%h",
                     addr, wr_en, r_en, data_i, eb.a, eb.w, eb.d);
          end
        end
      end
      if (rsp_done != '0 || rsp_err != '0) begin
        total++;
        if (exp_cpl.size() == 0) begin
          bad++;
          $display("FAIL cpl_unexpected done=%b err=%b", rsp_done, rsp_err);
        end else begin
          ec = exp_cpl.pop_front();
          if ({rsp_err, rsp_done} !== ec) begin
            bad++;
            $display("FAIL cpl got err/done=%b exp=%b", {rsp_err, rsp_done}, ec);
          end
        end
      end
    end
  end

  task automatic drive_client(input int c, input bit wr, input logic [31:0] a,
                              input logic [2:0] len, input logic [127:0] wd);
    req_wr[c]            = wr;
    req_addr[c*AW +: AW] = a;
    req_len[c*LW +: LW]  = len;
    req_wdata[c*128 +: 128] = wd;
  endtask

  // Raise req[c], count cycles (req cycle = 1) until its done/err, drop req.
  task automatic run_one(input int c, output int lat);
    lat = 0;
    @(posedge clk);
    #1 req[c] = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (rsp_done[c] || rsp_err[c]) begin
        lat = n;
        break;
      end
    end
    req[c] = 1'b0;
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #1;
    total++;
    if (exp_cpl.size() != 0 || exp_bus.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover cpl=%0d bus=%0d exp 0/0", name, exp_cpl.size(), exp_bus.size());
      exp_cpl.delete();
      exp_bus.delete();
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 8;
    if (wr_en !== 1'b0)     begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    if (r_en !== 1'b0)      begin bad++; $display("FAIL rst_r_en got=%b exp=0", r_en); end
    if (addr !== '0)        begin bad++; $display("FAIL rst_addr got=%h exp=0", addr); end
    if (data_i !== '0)      begin bad++; $display("FAIL rst_data_i got=%h exp=0", data_i); end
    if (rsp_rdata !== '0)   begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    if (rsp_done !== '0)    begin bad++; $display("FAIL rst_done got=%b exp=0", rsp_done); end
    if (rsp_err !== '0)     begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    if (select !== 4'hF)    begin bad++; $display("FAIL rst_select got=%h exp=f", select); end
    nRst = 1'b1;
  endtask

  task automatic test_single_read();
    int lat;
    rd_q.push_back(32'hA); rd_q.push_back(32'hB); rd_q.push_back(32'hC);
    exp_bus.push_back('{CB_BASE,        1'b0, 32'h0});
    exp_bus.push_back('{CB_BASE + 32'h4, 1'b0, 32'h0});
    exp_bus.push_back('{CB_BASE + 32'h8, 1'b0, 32'h0});
    exp_cpl.push_back(8'b0000_0100);
    drive_client(2, 1'b0, CB_BASE, 3'd3, '0);
    run_one(2, lat);
    total++;
    if (lat !== 11) begin bad++; $display("FAIL read3_latency got=%0d exp=11", lat); end
    drain("read3");
    total++;
    if (rsp_rdata !== 128'h0000_0000_0000_000C_0000_000B_0000_000A) begin
      bad++; $display("FAIL read3_rdata got=%h exp=c_b_a", rsp_rdata);
    end
  endtask

  task automatic test_zero_clamp();
    int lat, sc;
    sc = strobe_cnt;
    exp_cpl.push_back(8'b0000_1000);
    drive_client(3, 1'b0, TRN_BASE + 32'h40, 3'd0, '0);
    run_one(3, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    drain("zero");
    total++;
    if (strobe_cnt - sc !== 0) begin bad++; $display("FAIL zero_strobes got=%0d exp=0", strobe_cnt - sc); end

    sc = strobe_cnt;
    for (int k = 0; k < 4; k++) begin
      rd_q.push_back(32'hC0DE_0000 + 32'(k));
      exp_bus.push_back('{HIST_BASE + 32'h100 + 32'(4 * k), 1'b0, 32'h0});
    end
    exp_cpl.push_back(8'b0000_1000);
    drive_client(3, 1'b0, HIST_BASE + 32'h100, 3'd7, '0);
    run_one(3, lat);
    total++;
    if (lat !== 14) begin bad++; $display("FAIL clamp_latency got=%0d exp=14", lat); end
    drain("clamp");
    total += 2;
    if (strobe_cnt - sc !== 4) begin bad++; $display("FAIL clamp_strobes got=%0d exp=4", strobe_cnt - sc); end
    if (rsp_rdata !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
      bad++; $display("FAIL clamp_rdata got=%h exp=c0de0003..0", rsp_rdata);
    end
  endtask

  task automatic test_arbitration();
    int sc;
    for (int i = 0; i < NC; i++) begin
      drive_client(i, 1'b0, 32'h1000 + 32'(16 * i), 3'd1, '0);
      exp_bus.push_back('{32'h1000 + 32'(16 * i), 1'b0, 32'h0});
      rd_q.push_back(32'h50 + 32'(i));
      exp_cpl.push_back(8'(1 << i));
    end
    @(posedge clk);
    #1 req = 4'hF;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_cpl.size() == 0) break;
    end
    total++;
    if (exp_cpl.size() != 0) begin
      bad++; $display("FAIL arb_pending got=%0d exp=0", exp_cpl.size());
      exp_cpl.delete();
    end
    sc = strobe_cnt;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (strobe_cnt - sc !== 0) begin bad++; $display("FAIL arb_regrant got=%0d exp=0", strobe_cnt - sc); end
    req = '0;
    drain("arb");
    total++;
    if (rsp_rdata !== 128'h53) begin bad++; $display("FAIL arb_rdata got=%h exp=53", rsp_rdata); end
  endtask

  task automatic test_write();
    int lat;
    exp_bus.push_back('{HTREE_BASE,         1'b1, 32'h1111_1111});
    exp_bus.push_back('{HTREE_BASE + 32'h4, 1'b1, 32'h2222_2222});
    exp_cpl.push_back(8'b0000_0001);
    drive_client(0, 1'b1, HTREE_BASE, 3'd2, {64'h0, 32'h2222_2222, 32'h1111_1111});
    run_one(0, lat);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL write_latency got=%0d exp=8", lat); end
    drain("write");
    total++;
    if (rsp_rdata !== 128'h53) begin bad++; $display("FAIL write_rdata_hold got=%h exp=53", rsp_rdata); end
  endtask

  task automatic test_timeout();
    int lat, sc;
    sc = strobe_cnt;
    hang = 1'b1;
    exp_bus.push_back('{CB_BASE + 32'h20, 1'b0, 32'h0});
    exp_cpl.push_back(8'b0010_0000);
    drive_client(1, 1'b0, CB_BASE + 32'h20, 3'd2, '0);
    run_one(1, lat);
    total++;
    if (lat !== TO + 3) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO + 3); end
    drain("timeout");
    total += 2;
    if (strobe_cnt - sc !== 1) begin bad++; $display("FAIL timeout_strobes got=%0d exp=1", strobe_cnt - sc); end
    if (rsp_rdata !== '0) begin bad++; $display("FAIL timeout_rdata got=%h exp=0", rsp_rdata); end
    hang = 1'b0;

    rd_q.push_back(32'h77);
    exp_bus.push_back('{CB_BASE + 32'h80, 1'b0, 32'h0});
    exp_cpl.push_back(8'b0000_0100);
    drive_client(2, 1'b0, CB_BASE + 32'h80, 3'd1, '0);
    run_one(2, lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL after_timeout_latency got=%0d exp=5", lat); end
    drain("after_timeout");
    total++;
    if (rsp_rdata !== 128'h77) begin bad++; $display("FAIL after_timeout_rdata got=%h exp=77", rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    int lat, sc;
    bit seen;
    seen = 1'b0;
    sc = strobe_cnt;
    rd_q.push_back(32'h99);
    exp_bus.push_back('{HIST_BASE + 32'h10, 1'b0, 32'h0});
    drive_client(3, 1'b0, HIST_BASE + 32'h10, 3'd2, '0);
    @(posedge clk);
    #1 req[3] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (busy_o) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrst_busy got=0 exp=1"); end
    @(posedge clk);           // engine now in WAIT_DONE
    #3 nRst = 1'b0;
    #1;
    total += 5;
    if (addr !== '0)      begin bad++; $display("FAIL midrst_addr got=%h exp=0", addr); end
    if (r_en !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL midrst_strobe got=%b%b exp=00", r_en, wr_en); end
    if (rsp_rdata !== '0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", rsp_rdata); end
    if (rsp_done !== '0)  begin bad++; $display("FAIL midrst_done got=%b exp=0", rsp_done); end
    if (rsp_err !== '0)   begin bad++; $display("FAIL midrst_err got=%b exp=0", rsp_err); end
    req[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (strobe_cnt - sc !== 1) begin bad++; $display("FAIL midrst_strobes got=%0d exp=1", strobe_cnt - sc); end
    drain("midrst");

    rd_q.push_back(32'h1234_5678);
    exp_bus.push_back('{HIST_BASE + 32'h20, 1'b0, 32'h0});
    exp_cpl.push_back(8'b0000_0001);
    drive_client(0, 1'b0, HIST_BASE + 32'h20, 3'd1, '0);
    run_one(0, lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL post_rst_latency got=%0d exp=5", lat); end
    drain("post_rst");
    total++;
    if (rsp_rdata !== 128'h1234_5678) begin bad++; $display("FAIL post_rst_rdata got=%h exp=12345678", rsp_rdata); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_zero_clamp();
    test_arbitration();
    test_write();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
